// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment (FND) display path.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

  localparam logic [7:0] FND_0     = 8'hC0;
  localparam logic [7:0] FND_1     = 8'hF9;
  localparam logic [7:0] FND_2     = 8'hA4;
  localparam logic [7:0] FND_3     = 8'hB0;
  localparam logic [7:0] FND_4     = 8'h99;
  localparam logic [7:0] FND_5     = 8'h92;
  localparam logic [7:0] FND_6     = 8'h82;
  localparam logic [7:0] FND_7     = 8'hF8;
  localparam logic [7:0] FND_8     = 8'h80;
  localparam logic [7:0] FND_9     = 8'h90;
  localparam logic [7:0] FND_BLANK = 8'hFF;

  localparam logic [3:0] DIGIT_OFF = 4'b1111;

endpackage

// File: rtl/fnd_decoder.sv
// Combinational BCD to active-low 7-segment decoder; blank (or a non-BCD
// digit) yields all segments off. The decimal point is never driven.
module fnd_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] font
);

  always_comb begin
    font = FND_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    font = FND_0;
        4'd1:    font = FND_1;
        4'd2:    font = FND_2;
        4'd3:    font = FND_3;
        4'd4:    font = FND_4;
        4'd5:    font = FND_5;
        4'd6:    font = FND_6;
        4'd7:    font = FND_7;
        4'd8:    font = FND_8;
        4'd9:    font = FND_9;
        default: font = FND_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fnd_sum_display.sv
// Shows the 5-bit adder result {carry,sum} as right-aligned decimal on a
// 4-digit multiplexed common-anode FND; input is captured once per frame.
module fnd_sum_display
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_sum,
  input  logic       i_cout,
  output logic [3:0] o_fnd_digit,
  output logic [7:0] o_fnd_font
);

  localparam int unsigned    DivW   = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

  logic [DivW-1:0] r_div;
  logic [1:0]      r_idx;
  logic [1:0]      next_idx;
  logic [4:0]      r_val;
  logic [4:0]      cur_val;
  logic            tick;
  logic            wrap;
  logic [1:0]      tens;
  logic [3:0]      ones;
  logic [3:0]      dig_bcd;
  logic            dig_blank;
  logic [7:0]      dig_font;

  assign tick     = (r_div == DivMax);
  assign wrap     = tick && (r_idx == 2'd3);
  assign next_idx = r_idx + 2'd1;
  // Digit 0 of a new frame must show the value being captured on this edge.
  assign cur_val  = wrap ? {i_cout, i_sum} : r_val;

  // Compare/subtract split; ones is computed mod 16 on the low nibble,
  // which is exact since the remainder is always below 10.
  always_comb begin
    tens = 2'd0;
    ones = cur_val[3:0];
    if (cur_val >= 5'd30) begin
      tens = 2'd3;
      ones = cur_val[3:0] - 4'd14;
    end else if (cur_val >= 5'd20) begin
      tens = 2'd2;
      ones = cur_val[3:0] - 4'd4;
    end else if (cur_val >= 5'd10) begin
      tens = 2'd1;
      ones = cur_val[3:0] - 4'd10;
    end
  end

  always_comb begin
    dig_bcd   = ones;
    dig_blank = 1'b1;
    case (next_idx)
      2'd0: begin
        dig_bcd   = ones;
        dig_blank = 1'b0;
      end
      2'd1: begin
        dig_bcd   = {2'b00, tens};
        dig_blank = (tens == 2'd0);
      end
      default: begin
        dig_bcd   = ones;
        dig_blank = 1'b1;
      end
    endcase
  end

  fnd_decoder u_decoder (
    .bcd   (dig_bcd),
    .blank (dig_blank),
    .font  (dig_font)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div       <= '0;
      r_idx       <= 2'd3;
      r_val       <= '0;
      o_fnd_digit <= DIGIT_OFF;
      o_fnd_font  <= FND_BLANK;
    end else begin
      r_div <= tick ? '0 : r_div + DivW'(1);
      if (tick) begin
        r_idx       <= next_idx;
        o_fnd_digit <= ~(4'b0001 << next_idx);
        o_fnd_font  <= dig_font;
      end
      if (wrap) begin
        r_val <= cur_val;
      end
    end
  end

endmodule

// File: tb/tb_fnd_sum_display.sv
// Self-checking bench for fnd_sum_display with SCAN_DIV=4; expected digit
// and font derive from frame position and decimal arithmetic on the value.
module tb_fnd_sum_display;

  localparam int unsigned ScanDiv = 4;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       i_clk;
  logic       i_reset_n;
  logic [3:0] i_sum;
  logic       i_cout;
  logic [3:0] o_fnd_digit;
  logic [7:0] o_fnd_font;

  int checks;
  int errors;

  fnd_sum_display #(
    .SCAN_DIV (ScanDiv)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_sum       (i_sum),
    .i_cout      (i_cout),
    .o_fnd_digit (o_fnd_digit),
    .o_fnd_font  (o_fnd_font)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] exp_font(input int d, input int v);
    int t;
    t = v / 10;
    if (d == 0) return SEG[v % 10];
    if (d == 1) return (t == 0) ? 8'hFF : SEG[t];
    return 8'hFF;
  endfunction

  function automatic logic [3:0] exp_digit(input int d);
    logic [3:0] m;
    m = 4'b1111;
    m[d] = 1'b0;
    return m;
  endfunction

  task automatic set_input(input logic [4:0] v);
    {i_cout, i_sum} = v;
  endtask

  // Caller is positioned just before a wrap edge; checks one full frame
  // (4 digits x ScanDiv edges) and leaves the bench before the next wrap edge.
  task automatic run_frame(input logic [4:0] v, input int chg_at, input logic [4:0] chg_v,
                           input string tag);
    set_input(v);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < int'(ScanDiv); k++) begin
        @(posedge i_clk);
        #1;
        checks++;
        if (o_fnd_digit !== exp_digit(d) || o_fnd_font !== exp_font(d, int'(v))) begin
          errors++;
          $display("FAIL %s v=%0d digit%0d cyc%0d: got %b/%h want %b/%h", tag, v, d, k,
                   o_fnd_digit, o_fnd_font, exp_digit(d), exp_font(d, int'(v)));
        end
        if (d == chg_at && k == 0) set_input(chg_v);
      end
    end
  endtask

  // Releases reset with value v applied, checks the blank run-in and the
  // first frame, ending just before the next wrap edge.
  task automatic release_and_start(input logic [4:0] v, input string tag);
    set_input(v);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int e = 1; e < int'(ScanDiv); e++) begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_fnd_digit !== 4'b1111 || o_fnd_font !== 8'hFF) begin
        errors++;
        $display("FAIL %s runin edge%0d: got %b/%h want 1111/ff", tag, e, o_fnd_digit,
                 o_fnd_font);
      end
    end
    for (int idx = 0; idx < 4 * int'(ScanDiv); idx++) begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_fnd_digit !== exp_digit(idx / int'(ScanDiv)) ||
          o_fnd_font !== exp_font(idx / int'(ScanDiv), int'(v))) begin
        errors++;
        $display("FAIL %s first frame v=%0d step%0d: got %b/%h want %b/%h", tag, v, idx,
                 o_fnd_digit, o_fnd_font, exp_digit(idx / int'(ScanDiv)),
                 exp_font(idx / int'(ScanDiv), int'(v)));
      end
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    set_input(5'd0);
    repeat (3) begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_fnd_digit !== 4'b1111 || o_fnd_font !== 8'hFF) begin
        errors++;
        $display("FAIL reset hold: got %b/%h want 1111/ff", o_fnd_digit, o_fnd_font);
      end
    end
    release_and_start(5'd0, "reset");
  endtask

  task automatic test_value_31();
    run_frame(5'd31, -1, 5'd0, "val31");
  endtask

  task automatic test_value_5();
    run_frame(5'd5, -1, 5'd0, "val5");
  endtask

  task automatic test_mid_frame_change();
    run_frame(5'd12, 1, 5'd27, "chg12");
    run_frame(5'd27, -1, 5'd0, "chg27");
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 32; v++) run_frame(5'(v), -1, 5'd0, "sweep");
  endtask

  task automatic test_random();
    logic [4:0] v;
    logic [4:0] c;
    int         at;
    for (int n = 0; n < 16; n++) begin
      v  = 5'($urandom_range(31, 0));
      c  = 5'($urandom_range(31, 0));
      at = int'($urandom_range(3, 0));
      run_frame(v, at, c, "random");
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] v;
    v = 5'($urandom_range(31, 10));
    set_input(v);
    repeat (int'(ScanDiv) + 1) @(posedge i_clk);
    #1;
    checks++;
    if (o_fnd_digit !== 4'b1101 || o_fnd_font !== exp_font(1, int'(v))) begin
      errors++;
      $display("FAIL areset pre: got %b/%h want 1101/%h", o_fnd_digit, o_fnd_font,
               exp_font(1, int'(v)));
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_fnd_digit !== 4'b1111 || o_fnd_font !== 8'hFF) begin
      errors++;
      $display("FAIL areset async: got %b/%h want 1111/ff", o_fnd_digit, o_fnd_font);
    end
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_fnd_digit !== 4'b1111 || o_fnd_font !== 8'hFF) begin
      errors++;
      $display("FAIL areset held: got %b/%h want 1111/ff", o_fnd_digit, o_fnd_font);
    end
    release_and_start(5'($urandom_range(31, 0)), "areset");
    run_frame(5'd19, -1, 5'd0, "post_areset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_value_31();
    test_value_5();
    test_mid_frame_change();
    test_sweep();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
